ctrl_alu_pipe: RTL
==================

// Module: ctrl_alu_pipe
// PURPOSE
//  Parametrised, 2-stage pipelined control-transfer ALU for the EXECUTE stage. Resolves jumps/branches
//  (J, JAL, JR, JALR, BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ, BC1F, BC1T), computes link/next PC and the
//  mispredict flag, and holds a RECOVER state that squashes younger work until the front end flushes.
// PARAMETERS
//  DATA_W    32  operand width
//  PC_W      32  PC width (>= TARGET_W+2)
//  IMMD_W    16  branch immediate width
//  OPC_W     8   opcode width (opcodes are the codebase `JUMP..`BC1T macros)
//  TARGET_W  26  jump-target field width
//  TAG_W     6   instruction tag carried alongside the op
// PORTS
//  clk              in   1         clock
//  reset            in   1         synchronous, active-high reset
//  valid_i          in   1         input op valid
//  ready_o          out  1         block accepts op this cycle (valid_i && ready_o = accept)
//  opcode_i         in   OPC_W     operation
//  data1_i/data2_i  in   DATA_W    source operands
//  immd_i           in   IMMD_W    branch offset (words, signed)
//  pc_i             in   PC_W      PC of op
//  pred_target_i    in   PC_W      predicted target (jump field in [TARGET_W-1:0] for J/JAL)
//  pred_dir_i       in   1         predicted direction
//  tag_i            in   TAG_W     tag
//  stall_i          in   1         downstream cannot take valid_o this cycle
//  flush_i          in   1         front end redirected; clear pipe, leave RECOVER
//  valid_o          out  1         result valid
//  result_o         out  PC_W      link value (pc+8 for JAL/JALR, else 0)
//  next_pc_o        out  PC_W      resolved next PC
//  direction_o      out  1         resolved direction (conditional branches, else 0)
//  flags_o          out  8         [0]mispredict [1]exception(0) [2]executed [3]writes_reg [4]conditional [5]indirect [7:6]0
//  tag_o            out  TAG_W     tag of result
//  recover_o        out  1         state==RECOVER
// BEHAVIOUR
//  - Reset: all outputs 0, both stage valids 0, state RUN; ready_o=1 from first cycle after reset.
//  - Latency 2: op accepted in cycle N appears on valid_o in N+2 if no stall. Throughput 1/cycle.
//  - Stage1 registers inputs; stage1->stage2 path computes; stage2 registers outputs.
//  - Stall: when valid_o && stall_i, both stages hold; ready_o = !(valid_o && stall_i && s1_valid).
//  - Immediate: sext(immd_i) << 2 to DATA_W (true sign extension, MSB of immd_i replicated).
//  - Branch target = pc+8+simm if taken else pc+8, modulo 2^PC_W (wrap, no exception).
//  - J/JAL: next = {pc[PC_W-1:TARGET_W+2], target[TARGET_W-1:0], 2'b00}; never mispredict.
//  - JR/JALR: next = data1; mispredict = data1 != pred_target_i.
//  - Cond: BEQ d1==d2; BNE d1!=d2; BLEZ d1[MSB]|d1==0; BGTZ !d1[MSB]&d1!=0; BLTZ d1[MSB];
//    BGEZ !d1[MSB]. mispredict = dir != pred_dir_i.
//  - BC1F/BC1T: executed=1, next_pc=0, no mispredict (FP branches unsupported). Unknown opcode: flags=0, valid_o still 1.
//  - FSM RUN->RECOVER when a valid_o with flags_o[0]=1 is consumed (!stall_i). In RECOVER: stage1
//    content invalidated, ready_o=1, accepted ops dropped (never reach valid_o). RECOVER->RUN on flush_i.
//  - flush_i (any state): next cycle s1/s2 valid=0, state RUN; an op presented with flush_i is dropped;
//    flush_i overrides stall_i and a same-cycle mispredict consume.
//  - reset mid-operation discards all in-flight ops; reset overrides flush_i.
// CONFIGURATION
//  CTRL_ALU_STATS_EN defined: adds ports branch_cnt_o[31:0], mispred_cnt_o[31:0]; increment on each
//  consumed valid_o that is a control op / has flags_o[0]; saturate at 0xFFFFFFFF; cleared by reset only.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  1. BEQ pc=0x1000 d1=d2=5 immd=0xFFFF pred_dir=1 -> N+2: valid_o, next_pc=0x1004, dir=1, flags[0]=0.
//  2. BNE pc=0x2000 d1=1 d2=1 immd=0x0004 pred_dir=1 -> next_pc=0x2008, dir=0, flags[0]=1, recover_o=1 after consume.
//  3. In RECOVER send 3 ops -> none on valid_o; flush_i 1 cycle -> recover_o=0, next op emerges 2 cycles later.
//  4. Back-to-back JAL/JR with stall_i high 3 cycles -> outputs held, no loss/dup; JAL result=pc+8; JR d1=0x400 pred=0x404 -> mispredict.
//  5. pc=0xFFFFFFF8 BGEZ taken immd=0 -> next_pc=0x00000000 (wrap), no exception flag.
//  6. STATS_EN: 10 branches, 3 mispredicts consumed -> branch_cnt_o=10, mispred_cnt_o=3; reset mid-stream clears pipe and counters.

Source files
------------

// File: rtl/ctrl_alu_pipe_if.sv
// ctrl_alu_pipe_if: op/result bus of the control-transfer ALU; master drives ops, slave is the ALU.
interface ctrl_alu_pipe_if #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int IMMD_W = 16,
    parameter int OPC_W  = 8,
    parameter int TAG_W  = 6
);
    logic              valid_i;
    logic              ready_o;
    logic [OPC_W-1:0]  opcode_i;
    logic [DATA_W-1:0] data1_i;
    logic [DATA_W-1:0] data2_i;
    logic [IMMD_W-1:0] immd_i;
    logic [PC_W-1:0]   pc_i;
    logic [PC_W-1:0]   pred_target_i;
    logic              pred_dir_i;
    logic [TAG_W-1:0]  tag_i;
    logic              stall_i;
    logic              flush_i;
    logic              valid_o;
    logic [PC_W-1:0]   result_o;
    logic [PC_W-1:0]   next_pc_o;
    logic              direction_o;
    logic [7:0]        flags_o;
    logic [TAG_W-1:0]  tag_o;
    logic              recover_o;

    modport master (
        output valid_i, opcode_i, data1_i, data2_i, immd_i, pc_i, pred_target_i, pred_dir_i, tag_i,
               stall_i, flush_i,
        input  ready_o, valid_o, result_o, next_pc_o, direction_o, flags_o, tag_o, recover_o
    );
    modport slave (
        input  valid_i, opcode_i, data1_i, data2_i, immd_i, pc_i, pred_target_i, pred_dir_i, tag_i,
               stall_i, flush_i,
        output ready_o, valid_o, result_o, next_pc_o, direction_o, flags_o, tag_o, recover_o
    );
endinterface

// File: rtl/ctrl_alu_pipe.sv
// ctrl_alu_pipe: 2-stage jump/branch resolver with a RECOVER state that squashes younger ops until flush.
// Define CTRL_ALU_STATS_EN to add saturating branch_cnt_o / mispred_cnt_o counters.
`ifndef JUMP
`define JUMP 1
`define JAL  2
`define JR   3
`define JALR 4
`define BEQ  5
`define BNE  6
`define BLEZ 7
`define BGTZ 8
`define BLTZ 9
`define BGEZ 10
`define BC1F 11
`define BC1T 12
`endif

module ctrl_alu_pipe #(
    parameter int DATA_W   = 32,
    parameter int PC_W     = 32,
    parameter int IMMD_W   = 16,
    parameter int OPC_W    = 8,
    parameter int TARGET_W = 26,
    parameter int TAG_W    = 6
) (
    input  logic clk,
    input  logic reset,
`ifdef CTRL_ALU_STATS_EN
    output logic [31:0] branch_cnt_o,
    output logic [31:0] mispred_cnt_o,
`endif
    ctrl_alu_pipe_if.slave bus
);
    localparam logic [OPC_W-1:0] OP_J    = OPC_W'(`JUMP);
    localparam logic [OPC_W-1:0] OP_JAL  = OPC_W'(`JAL);
    localparam logic [OPC_W-1:0] OP_JR   = OPC_W'(`JR);
    localparam logic [OPC_W-1:0] OP_JALR = OPC_W'(`JALR);
    localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(`BEQ);
    localparam logic [OPC_W-1:0] OP_BNE  = OPC_W'(`BNE);
    localparam logic [OPC_W-1:0] OP_BLEZ = OPC_W'(`BLEZ);
    localparam logic [OPC_W-1:0] OP_BGTZ = OPC_W'(`BGTZ);
    localparam logic [OPC_W-1:0] OP_BLTZ = OPC_W'(`BLTZ);
    localparam logic [OPC_W-1:0] OP_BGEZ = OPC_W'(`BGEZ);
    localparam logic [OPC_W-1:0] OP_BC1F = OPC_W'(`BC1F);
    localparam logic [OPC_W-1:0] OP_BC1T = OPC_W'(`BC1T);
    localparam logic [0:0] RUN     = 1'b0;
    localparam logic [0:0] RECOVER = 1'b1;

    logic [0:0]        state_q, state_d;
    logic              s1_valid_q, s1_valid_d;
    logic [OPC_W-1:0]  s1_opc_q;
    logic [DATA_W-1:0] s1_d1_q, s1_d2_q;
    logic [IMMD_W-1:0] s1_immd_q;
    logic [PC_W-1:0]   s1_pc_q, s1_pt_q;
    logic              s1_pd_q;
    logic [TAG_W-1:0]  s1_tag_q;
    logic              valid_q, valid_d;
    logic [PC_W-1:0]   result_q, result_d, next_pc_q, next_pc_d;
    logic              dir_q, dir_d;
    logic [7:0]        flags_q, flags_d;
    logic [TAG_W-1:0]  tag_q;
    logic              hold, consume, mis_consume, load, accept;
    logic [PC_W-1:0]   pc8, simm, jtgt, d1pc;
    logic              neg, zero, taken, is_cond, is_jump, is_ind, is_link, is_fp, known, mis;

    assign hold        = valid_q && bus.stall_i;
    assign consume     = valid_q && !bus.stall_i;
    assign mis_consume = consume && flags_q[0];
    assign bus.ready_o = state_q == RECOVER || !(hold && s1_valid_q);
    assign load        = bus.valid_i && bus.ready_o && !bus.flush_i;
    // ops arriving in RECOVER or alongside the mispredict consume are younger work: drop them
    assign accept      = load && state_q == RUN && !mis_consume;

    assign state_d    = bus.flush_i ? RUN : mis_consume ? RECOVER : state_q;
    assign s1_valid_d = !bus.flush_i && (accept || (hold && s1_valid_q));
    assign valid_d    = !bus.flush_i && (hold || (s1_valid_q && !mis_consume));

    assign pc8  = s1_pc_q + PC_W'(8);
    assign simm = {{(PC_W-IMMD_W-2){s1_immd_q[IMMD_W-1]}}, s1_immd_q, 2'b00};
    assign jtgt = {s1_pc_q[PC_W-1:TARGET_W+2], s1_pt_q[TARGET_W-1:0], 2'b00};
    assign d1pc = PC_W'(s1_d1_q);
    assign neg  = s1_d1_q[DATA_W-1];
    assign zero = s1_d1_q == '0;

    always_comb begin
        is_cond = 1'b0;
        taken = 1'b0;
        case (s1_opc_q)
            OP_BEQ:  {is_cond, taken} = {1'b1, s1_d1_q == s1_d2_q};
            OP_BNE:  {is_cond, taken} = {1'b1, s1_d1_q != s1_d2_q};
            OP_BLEZ: {is_cond, taken} = {1'b1, neg || zero};
            OP_BGTZ: {is_cond, taken} = {1'b1, !neg && !zero};
            OP_BLTZ: {is_cond, taken} = {1'b1, neg};
            OP_BGEZ: {is_cond, taken} = {1'b1, !neg};
            default: ;
        endcase
    end

    assign is_jump = s1_opc_q == OP_J || s1_opc_q == OP_JAL;
    assign is_ind  = s1_opc_q == OP_JR || s1_opc_q == OP_JALR;
    assign is_link = s1_opc_q == OP_JAL || s1_opc_q == OP_JALR;
    assign is_fp   = s1_opc_q == OP_BC1F || s1_opc_q == OP_BC1T;
    assign known   = is_jump || is_ind || is_cond || is_fp;
    assign mis     = is_ind ? d1pc != s1_pt_q : is_cond && taken != s1_pd_q;

    assign result_d  = is_link ? pc8 : '0;
    assign next_pc_d = is_jump ? jtgt : is_ind ? d1pc : is_cond ? (taken ? pc8 + simm : pc8) : '0;
    assign dir_d     = is_cond && taken;
    assign flags_d   = {2'b00, is_ind, is_cond, is_link, known, 1'b0, mis};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            s1_valid_q <= 1'b0;
            valid_q    <= 1'b0;
            result_q   <= '0;
            next_pc_q  <= '0;
            dir_q      <= 1'b0;
            flags_q    <= '0;
            tag_q      <= '0;
        end else begin
            state_q    <= state_d;
            s1_valid_q <= s1_valid_d;
            valid_q    <= valid_d;
            if (!hold && s1_valid_q) begin
                result_q  <= result_d;
                next_pc_q <= next_pc_d;
                dir_q     <= dir_d;
                flags_q   <= flags_d;
                tag_q     <= s1_tag_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            s1_opc_q  <= bus.opcode_i;
            s1_d1_q   <= bus.data1_i;
            s1_d2_q   <= bus.data2_i;
            s1_immd_q <= bus.immd_i;
            s1_pc_q   <= bus.pc_i;
            s1_pt_q   <= bus.pred_target_i;
            s1_pd_q   <= bus.pred_dir_i;
            s1_tag_q  <= bus.tag_i;
        end
    end

    assign bus.valid_o     = valid_q;
    assign bus.result_o    = result_q;
    assign bus.next_pc_o   = next_pc_q;
    assign bus.direction_o = dir_q;
    assign bus.flags_o     = flags_q;
    assign bus.tag_o       = tag_q;
    assign bus.recover_o   = state_q == RECOVER;

`ifdef CTRL_ALU_STATS_EN
    logic [31:0] branch_cnt_q, mispred_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else if (consume) begin
            if (flags_q[2] && branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + 32'd1;
            if (flags_q[0] && mispred_cnt_q != '1) mispred_cnt_q <= mispred_cnt_q + 32'd1;
        end
    end

    assign branch_cnt_o  = branch_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;
`endif
endmodule
